// File: rtl/mult_share_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mult_share_arbiter
// Description : Shares a single unsigned WIDTH x WIDTH multiplier among NREQ
//               requesters. Round-robin grant, one operation in flight at a
//               time. Operands and product are registered. The result returns
//               on a shared bus tagged with a one-hot requester id.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clk        in   1            system clock, rising edge
//   rst        in   1            asynchronous reset, active-high
//   req_valid  in   NREQ         per-requester request valid
//   req_ready  out  NREQ         per-requester accept (at most one bit high)
//   req_a      in   NREQ*WIDTH   operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH   operand B, same packing as req_a
//   rsp_valid  out  NREQ         one-hot owner of the result on rsp_data
//   rsp_data   out  2*WIDTH      unsigned product A*B
//   rsp_ready  in   1            shared consumer accepts the result
//   busy       out  1            high whenever the FSM is not idle
//------------------------------------------------------------------------------
module mult_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]      rsp_data,
  input  logic                    rsp_ready,
  output logic                    busy
);

  localparam int                PTRW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int                PW     = 2 * WIDTH;
  localparam logic [PTRW:0]     C_NREQ = (PTRW+1)'(NREQ);
  localparam logic [PTRW-1:0]   C_LAST = PTRW'(NREQ - 1);
  localparam logic [NREQ-1:0]   C_ONE  = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PTRW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTRW-1:0]   id_q, id_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [PW-1:0]     prod_q, prod_d;

  logic [PTRW-1:0]   grant;
  logic              grant_found;
  logic [PTRW:0]     cand;

  // Round-robin search starting at rr_ptr. The candidate index is kept one
  // bit wider so the modulo-NREQ wrap is a single conditional subtract.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (PTRW+1)'(k);
      if (cand >= C_NREQ) begin
        cand = cand - C_NREQ;
      end
      if (!grant_found && req_valid[cand[PTRW-1:0]]) begin
        grant_found = 1'b1;
        grant       = cand[PTRW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    prod_d    = prod_q;
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        // The granted requester is valid by construction, so a grant is
        // also the handshake. req_ready is held low while reset is applied.
        if (grant_found) begin
          req_ready = rst ? '0 : (C_ONE << grant);
          a_d       = req_a[grant*WIDTH +: WIDTH];
          b_d       = req_b[grant*WIDTH +: WIDTH];
          id_d      = grant;
          rr_ptr_d  = (grant == C_LAST) ? '0 : grant + 1'b1;
          state_d   = ST_MUL;
        end
      end
      ST_MUL: begin
        prod_d  = PW'(a_q) * PW'(b_q);
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = C_ONE << id_q;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
    end
  end

  // The product register holds its value after the response handshake.
  assign rsp_data = prod_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_mult_share_arbiter
// Description : Self-checking bench for mult_share_arbiter (NREQ=4, WIDTH=4).
//               A round-robin pointer model and plain arithmetic products
//               supply every expected value.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mult_share_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_ready;
  logic        busy;

  int total;
  int bad;
  int m_ptr;   // reference round-robin pointer

  mult_share_arbiter #(
    .NREQ  (4),
    .WIDTH (4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction starting from idle. stall = number of response
  // cycles with rsp_ready low (0 means rsp_ready is already high on entry).
  task automatic run_txn(input logic [3:0] vmask, input logic [15:0] av,
                         input logic [15:0] bv, input int stall, output int g);
    int         exp_g;
    int         ea;
    int         eb;
    logic [7:0] exp_p;
    logic [3:0] oh;
    exp_g = -1;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (exp_g < 0 && vmask[idx]) exp_g = idx;
    end
    ea    = int'(av[exp_g*4 +: 4]);
    eb    = int'(bv[exp_g*4 +: 4]);
    exp_p = 8'(ea * eb);
    oh    = 4'(1 << exp_g);

    req_valid = vmask;
    req_a     = av;
    req_b     = bv;
    rsp_ready = (stall == 0);
    #1;
    total++;
    if (req_ready !== oh) begin
      bad++;
      $display("FAIL grant_ready: got %b expected %b (ptr=%0d valid=%b)", req_ready, oh, m_ptr, vmask);
    end

    tick();
    m_ptr = (exp_g + 1) % 4;
    req_valid[exp_g] = 1'b0;
    total++;
    if (busy !== 1'b1 || rsp_valid !== 4'b0000 || req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL mul_cycle: busy=%b rsp_valid=%b req_ready=%b expected 1/0000/0000", busy, rsp_valid, req_ready);
    end

    tick();
    total++;
    if (rsp_valid !== oh || rsp_data !== exp_p || req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL resp: rsp_valid=%b rsp_data=%0d req_ready=%b expected %b/%0d/0000", rsp_valid, rsp_data, req_ready, oh, exp_p);
    end

    for (int s = 1; s < stall; s++) begin
      tick();
      total++;
      if (rsp_valid !== oh || rsp_data !== exp_p || req_ready !== 4'b0000 || busy !== 1'b1) begin
        bad++;
        $display("FAIL resp_hold: cycle %0d rsp_valid=%b rsp_data=%0d req_ready=%b expected %b/%0d/0000", s, rsp_valid, rsp_data, req_ready, oh, exp_p);
      end
    end

    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++;
    if (busy !== 1'b0 || rsp_valid !== 4'b0000 || rsp_data !== exp_p) begin
      bad++;
      $display("FAIL resp_done: busy=%b rsp_valid=%b rsp_data=%0d expected 0/0000/%0d", busy, rsp_valid, rsp_data, exp_p);
    end
    g = exp_g;
  endtask

  task automatic test_reset();
    int g;
    // Power-on reset
    rst = 1'b1; req_valid = 4'b0001; req_a = 16'h0003; req_b = 16'h0005; rsp_ready = 1'b0;
    #2;
    total++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0 || req_ready !== 4'b0000 || rsp_data !== 8'd0) begin
      bad++;
      $display("FAIL reset_por: rsp_valid=%b busy=%b req_ready=%b rsp_data=%0d expected all 0", rsp_valid, busy, req_ready, rsp_data);
    end
    #10 rst = 1'b0;
    m_ptr = 0;
    tick();
    // Drive a request into the response state, then reset mid-response
    req_valid = 4'b0001; req_a = 16'h0003; req_b = 16'h0005; rsp_ready = 1'b0;
    tick();
    req_valid = 4'b0000;
    tick();
    total++;
    if (rsp_valid !== 4'b0001) begin
      bad++;
      $display("FAIL reset_setup: rsp_valid=%b expected 0001", rsp_valid);
    end
    req_valid = 4'b0100;
    #2 rst = 1'b1;
    #1;
    total++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL reset_async: rsp_valid=%b busy=%b req_ready=%b expected 0000/0/0000", rsp_valid, busy, req_ready);
    end
    req_valid = 4'b0000;
    tick();
    rst = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_resp: cycle %0d rsp_valid=%b busy=%b expected 0000/0", i, rsp_valid, busy);
      end
    end
    // Pointer restarted at 0: with req1 and req0 valid, req0 wins
    run_txn(4'b0011, 16'h0021, 16'h0043, 0, g);
    total++;
    if (g != 0) begin
      bad++;
      $display("FAIL reset_ptr: granted %0d expected 0", g);
    end
  endtask

  task automatic test_round_robin();
    int g;
    int order [5];
    for (int i = 0; i < 5; i++) begin
      run_txn(4'b1111, 16'($urandom), 16'($urandom), 0, g);
      order[i] = g;
    end
    // pointer was 1 after the previous task's grant of 0
    for (int i = 0; i < 5; i++) begin
      total++;
      if (order[i] != (i + 1) % 4) begin
        bad++;
        $display("FAIL rr_order: grant %0d was %0d expected %0d", i, order[i], (i + 1) % 4);
      end
    end
  endtask

  task automatic test_single();
    int g;
    run_txn(4'b0001, 16'h0003, 16'h0005, 0, g);
    total++;
    if (g != 0) begin
      bad++;
      $display("FAIL single_id: granted %0d expected 0", g);
    end
  endtask

  task automatic test_max();
    int g;
    run_txn(4'b0100, 16'h0F00, 16'h0F00, 0, g);
    total++;
    if (g != 2) begin
      bad++;
      $display("FAIL max_id: granted %0d expected 2", g);
    end
  endtask

  task automatic test_backpressure();
    int g;
    run_txn(4'b0010, 16'h0070, 16'h0090, 5, g);
    total++;
    if (g != 1) begin
      bad++;
      $display("FAIL bp_id: granted %0d expected 1", g);
    end
  endtask

  task automatic test_ptr_wrap();
    int g;
    run_txn(4'b0100, 16'h0300, 16'h0500, 0, g);      // pointer -> 3
    run_txn(4'b0010, 16'h00B0, 16'h00C0, 1, g);      // skip 3,0 -> req1
    total++;
    if (g != 1) begin
      bad++;
      $display("FAIL skip_grant: granted %0d expected 1", g);
    end
    run_txn(4'b1001, 16'hD00E, 16'h2003, 0, g);      // from 2: req3
    total++;
    if (g != 3) begin
      bad++;
      $display("FAIL wrap_grant: granted %0d expected 3", g);
    end
    run_txn(4'b0011, 16'h0064, 16'h0087, 0, g);      // wrapped to 0
    total++;
    if (g != 0) begin
      bad++;
      $display("FAIL wrap_ptr: granted %0d expected 0", g);
    end
  endtask

  task automatic test_random();
    int g;
    for (int i = 0; i < 25; i++) begin
      run_txn(4'($urandom_range(1, 15)), 16'($urandom), 16'($urandom),
              int'($urandom_range(0, 3)), g);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m_ptr = 0;
    test_reset();
    test_round_robin();
    test_single();
    test_max();
    test_backpressure();
    test_ptr_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
